// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single register-file read port and write port among
// NUM_REQ execution units. Transactions run one at a time: a grant with a one-cycle
// write strobe (WR), or a grant with a one-cycle read strobe (RD), followed by
// RF_LAT-1 wait cycles (WAIT) and a capture cycle (CAP) that returns the data.
//
// Build option: define REGFILE_ARB_FIXED_PRIO_EN to use fixed priority, where the
// lowest pending index always wins. The default is round-robin, resuming after the
// last winner.
//
// Ports (all outputs registered, all reset to 0):
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i               per-requester request, held until its grant
//   req_write_i         per-requester 1 = write, 0 = read
//   req_reg_i           per-requester register index, slice i = [4i+3:4i]
//   req_wdata_i         per-requester write data, slice i = [32i+31:32i]
//   gnt_o               one-hot grant pulse
//   rsp_valid_o         one-hot read-response pulse
//   rsp_data_o          last captured read data
//   rf_read_en_o        read strobe to the register file
//   rf_read_reg_o       read index to the register file
//   rf_read_value_i     read data from the register file
//   rf_write_en_o       write strobe to the register file
//   rf_write_reg_o      write index to the register file
//   rf_write_value_o    write data to the register file
//   busy_o              a transaction is in progress
module regfile_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned RF_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [4*NUM_REQ-1:0]    req_reg_i,
    input  logic [32*NUM_REQ-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic                    rf_read_en_o,
    output logic [3:0]              rf_read_reg_o,
    input  logic [31:0]             rf_read_value_i,
    output logic                    rf_write_en_o,
    output logic [3:0]              rf_write_reg_o,
    output logic [31:0]             rf_write_value_o,
    output logic                    busy_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {StIdle, StWr, StRd, StWait, StCap} state_e;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    // Last winner: round-robin pointer and target of the pending read response.
    logic [IdxW-1:0]      sel_q, sel_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rf_read_en_q, rf_read_en_d;
    logic [3:0]           rf_read_reg_q, rf_read_reg_d;
    logic                 rf_write_en_q, rf_write_en_d;
    logic [3:0]           rf_write_reg_q, rf_write_reg_d;
    logic [31:0]          rf_write_value_q, rf_write_value_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [IdxW-1:0]      win;
    int unsigned          idx;

    // Winner selection among pending requests.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (32'(sel_q) + 32'd1 + k) % NUM_REQ;
`endif
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = IdxW'(idx);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sel_d            = sel_q;
        gnt_d            = '0;
        rsp_valid_d      = '0;
        rsp_data_d       = rsp_data_q;
        rf_read_en_d     = 1'b0;
        rf_read_reg_d    = rf_read_reg_q;
        rf_write_en_d    = 1'b0;
        rf_write_reg_d   = rf_write_reg_q;
        rf_write_value_d = rf_write_value_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d      = win;
                    gnt_d[win] = 1'b1;
                    if (req_write_i[win]) begin
                        state_d          = StWr;
                        rf_write_en_d    = 1'b1;
                        rf_write_reg_d   = req_reg_i[32'(win)*4 +: 4];
                        rf_write_value_d = req_wdata_i[32'(win)*32 +: 32];
                    end else begin
                        state_d       = StRd;
                        rf_read_en_d  = 1'b1;
                        rf_read_reg_d = req_reg_i[32'(win)*4 +: 4];
                    end
                end
            end
            StWr: begin
                state_d = StIdle;
            end
            StRd: begin
                cnt_d   = 3'(RF_LAT - 1);
                state_d = (RF_LAT > 1) ? StWait : StCap;
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StCap;
                end
            end
            StCap: begin
                // Exactly RF_LAT cycles after the read strobe.
                rsp_data_d         = rf_read_value_i;
                rsp_valid_d[sel_q] = 1'b1;
                state_d            = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            sel_q            <= IdxW'(NUM_REQ - 1);
            gnt_q            <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            rf_read_en_q     <= 1'b0;
            rf_read_reg_q    <= '0;
            rf_write_en_q    <= 1'b0;
            rf_write_reg_q   <= '0;
            rf_write_value_q <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            sel_q            <= sel_d;
            gnt_q            <= gnt_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            rf_read_en_q     <= rf_read_en_d;
            rf_read_reg_q    <= rf_read_reg_d;
            rf_write_en_q    <= rf_write_en_d;
            rf_write_reg_q   <= rf_write_reg_d;
            rf_write_value_q <= rf_write_value_d;
            busy_q           <= busy_d;
        end
    end

    assign gnt_o            = gnt_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rf_read_en_o     = rf_read_en_q;
    assign rf_read_reg_o    = rf_read_reg_q;
    assign rf_write_en_o    = rf_write_en_q;
    assign rf_write_reg_o   = rf_write_reg_q;
    assign rf_write_value_o = rf_write_value_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter (NUM_REQ=3, RF_LAT=2). Expected grants and read
// responses are queued when a request is driven and popped when the DUT shows them.
module tb_regfile_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned RF_LAT  = 2;

    typedef struct packed {
        logic [NUM_REQ-1:0] oh;
        logic               wr;
        logic [3:0]         rg;
        logic [31:0]        data;
    } txn_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req, req_write;
    logic [4*NUM_REQ-1:0]  req_reg;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    gnt, rsp_valid;
    logic [31:0]           rsp_data, rf_read_value, rf_write_value;
    logic                  rf_read_en, rf_write_en, busy;
    logic [3:0]            rf_read_reg, rf_write_reg;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   rsp_seen = 0;
    txn_t exp_q[$];
    txn_t rsp_q[$];

    regfile_arbiter #(.NUM_REQ(NUM_REQ), .RF_LAT(RF_LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req),
        .req_write_i      (req_write),
        .req_reg_i        (req_reg),
        .req_wdata_i      (req_wdata),
        .gnt_o            (gnt),
        .rsp_valid_o      (rsp_valid),
        .rsp_data_o       (rsp_data),
        .rf_read_en_o     (rf_read_en),
        .rf_read_reg_o    (rf_read_reg),
        .rf_read_value_i  (rf_read_value),
        .rf_write_en_o    (rf_write_en),
        .rf_write_reg_o   (rf_write_reg),
        .rf_write_value_o (rf_write_value),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    // Register-file model: data appears RF_LAT cycles after the read strobe cycle.
    logic [31:0]       mem [16];
    logic [RF_LAT-1:0] pv;
    logic [3:0]        pr [RF_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            for (int i = RF_LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
            end
            pv[0] <= rf_read_en;
            pr[0] <= rf_read_reg;
        end
    end
    assign rf_read_value = pv[RF_LAT-1] ? mem[pr[RF_LAT-1]] : 32'hBAD0_BAD0;

    // Advance to the next falling edge; granted requesters drop their request.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rsp_valid !== '0) rsp_seen = 1;
        req = req & ~gnt;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt !== '0) break;
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== '0) break;
        end
    endtask

    task automatic set_op(input int i, input logic wr, input logic [3:0] rg,
                          input logic [31:0] d);
        req_write[i]       = wr;
        req_reg[i*4 +: 4]  = rg;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        txn_t e;
        rst_n = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 3; i++) set_op(i, 1'b1, 4'(i + 1), 32'h1000_0000 + i);
        repeat (3) tick();
        req = 3'b111;
        vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL rst_gnt got %b want 0", gnt); end
        vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== '0) begin miscompares++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
        vectors++; if (rf_read_en !== 1'b0 || rf_read_reg !== '0) begin miscompares++; $display("FAIL rst_read got %b/%h want 0/0", rf_read_en, rf_read_reg); end
        vectors++; if (rf_write_en !== 1'b0 || rf_write_reg !== '0) begin miscompares++; $display("FAIL rst_write got %b/%h want 0/0", rf_write_en, rf_write_reg); end
        vectors++; if (rf_write_value !== '0) begin miscompares++; $display("FAIL rst_wvalue got %h want 0", rf_write_value); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        exp_q.push_back('{oh: 3'b001, wr: 1'b1, rg: 4'd1, data: 32'h1000_0000});
        rst_n = 1'b1;
        wait_gnt();
        req = '0;
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL first_gnt got %b want %b", gnt, e.oh); end
        vectors++; if (rf_write_en !== 1'b1 || rf_write_reg !== e.rg || rf_write_value !== e.data) begin
            miscompares++; $display("FAIL first_write got %b/%h/%h want 1/%h/%h", rf_write_en, rf_write_reg, rf_write_value, e.rg, e.data); end
        tick();
    endtask

    task automatic test_single_write();
        txn_t e;
        set_op(1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        exp_q.push_back('{oh: 3'b010, wr: 1'b1, rg: 4'd3, data: 32'hDEAD_BEEF});
        req = 3'b010;
        wait_gnt();
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL wr_gnt got %b want %b", gnt, e.oh); end
        vectors++; if (rf_write_en !== 1'b1 || rf_read_en !== 1'b0) begin miscompares++; $display("FAIL wr_strobes got w%b r%b want w1 r0", rf_write_en, rf_read_en); end
        vectors++; if (rf_write_reg !== e.rg || rf_write_value !== e.data) begin
            miscompares++; $display("FAIL wr_payload got %h/%h want %h/%h", rf_write_reg, rf_write_value, e.rg, e.data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", busy); end
        tick();
        vectors++; if (rf_write_en !== 1'b0 || gnt !== '0) begin miscompares++; $display("FAIL wr_one_cycle got w%b g%b want w0 g000", rf_write_en, gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_after got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        txn_t e, r;
        int   t0;
        mem[7] = 32'h1234_5678;
        set_op(2, 1'b0, 4'd7, 32'h0);
        exp_q.push_back('{oh: 3'b100, wr: 1'b0, rg: 4'd7, data: 32'h0});
        rsp_q.push_back('{oh: 3'b100, wr: 1'b0, rg: 4'd7, data: 32'h1234_5678});
        req = 3'b100;
        wait_gnt();
        t0 = cyc;
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL rd_gnt got %b want %b", gnt, e.oh); end
        vectors++; if (rf_read_en !== 1'b1 || rf_read_reg !== e.rg || rf_write_en !== 1'b0) begin
            miscompares++; $display("FAIL rd_strobe got r%b reg %h w%b want r1 reg %h w0", rf_read_en, rf_read_reg, rf_write_en, e.rg); end
        wait_rsp();
        r = rsp_q.pop_front();
        vectors++; if (rsp_valid !== r.oh) begin miscompares++; $display("FAIL rd_rsp_valid got %b want %b", rsp_valid, r.oh); end
        vectors++; if (rsp_data !== r.data) begin miscompares++; $display("FAIL rd_rsp_data got %h want %h", rsp_data, r.data); end
        vectors++; if (cyc - t0 !== 3) begin miscompares++; $display("FAIL rd_latency got %0d want 3", cyc - t0); end
        tick();
        vectors++; if (rsp_valid !== '0 || rsp_data !== r.data) begin
            miscompares++; $display("FAIL rd_hold got %b/%h want 000/%h", rsp_valid, rsp_data, r.data); end
    endtask

    task automatic test_round_robin();
        txn_t e;
        int   w;
        for (int i = 0; i < 3; i++) set_op(i, 1'b1, 4'(i + 4), 32'hA000_0000 + i);
        for (int k = 0; k < 6; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = k % 3;
`endif
            exp_q.push_back('{oh: 3'(1 << w), wr: 1'b1, rg: 4'(w + 4), data: 32'hA000_0000 + w});
        end
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_gnt();
            e = exp_q.pop_front();
            vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, e.oh); end
            vectors++; if (rf_write_reg !== e.rg || rf_write_value !== e.data) begin
                miscompares++; $display("FAIL rr_payload[%0d] got %h/%h want %h/%h", k, rf_write_reg, rf_write_value, e.rg, e.data); end
            tick();
            if (k < 5) req = 3'b111;
        end
        req = '0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle got busy %b want 0", busy); end
    endtask

    task automatic test_busy_block();
        txn_t e, r;
        mem[5] = 32'h5555_AAAA;
        set_op(0, 1'b0, 4'd5, 32'h0);
        set_op(1, 1'b1, 4'd2, 32'hCAFE_0001);
        exp_q.push_back('{oh: 3'b001, wr: 1'b0, rg: 4'd5, data: 32'h0});
        rsp_q.push_back('{oh: 3'b001, wr: 1'b0, rg: 4'd5, data: 32'h5555_AAAA});
        exp_q.push_back('{oh: 3'b010, wr: 1'b1, rg: 4'd2, data: 32'hCAFE_0001});
        req = 3'b001;
        wait_gnt();
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh || rf_read_en !== 1'b1) begin miscompares++; $display("FAIL blk_rd_gnt got %b/%b want %b/1", gnt, rf_read_en, e.oh); end
        tick();
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL blk_no_gnt got %b want 000", gnt); end
            vectors++; if (rf_read_en && rf_write_en) begin miscompares++; $display("FAIL blk_overlap got r1 w1 want no overlap"); end
            if (rsp_valid !== '0) break;
        end
        r = rsp_q.pop_front();
        vectors++; if (rsp_valid !== r.oh || rsp_data !== r.data) begin
            miscompares++; $display("FAIL blk_rsp got %b/%h want %b/%h", rsp_valid, rsp_data, r.oh, r.data); end
        wait_gnt();
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL blk_wr_gnt got %b want %b", gnt, e.oh); end
        vectors++; if (rf_write_en !== 1'b1 || rf_read_en !== 1'b0 || rf_write_reg !== e.rg || rf_write_value !== e.data) begin
            miscompares++; $display("FAIL blk_wr got w%b r%b %h/%h want w1 r0 %h/%h", rf_write_en, rf_read_en, rf_write_reg, rf_write_value, e.rg, e.data); end
        tick();
    endtask

    task automatic test_mid_read_reset();
        txn_t e;
        mem[9] = 32'h9999_0009;
        set_op(0, 1'b0, 4'd9, 32'h0);
        exp_q.push_back('{oh: 3'b001, wr: 1'b0, rg: 4'd9, data: 32'h0});
        req = 3'b001;
        wait_gnt();
        e = exp_q.pop_front();
        vectors++; if (gnt !== e.oh || rf_read_en !== 1'b1) begin miscompares++; $display("FAIL mrr_gnt got %b/%b want %b/1", gnt, rf_read_en, e.oh); end
        tick();
        rsp_seen = 0;
        set_op(0, 1'b1, 4'd1, 32'h1111_0000);
        set_op(2, 1'b1, 4'd15, 32'hFFFF_0015);
        req = 3'b101;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || gnt !== '0 || rf_read_en !== 1'b0) begin
            miscompares++; $display("FAIL mrr_async got busy %b gnt %b rd %b want 0/000/0", busy, gnt, rf_read_en); end
        repeat (2) tick();
        exp_q.push_back('{oh: 3'b001, wr: 1'b1, rg: 4'd1, data: 32'h1111_0000});
        exp_q.push_back('{oh: 3'b100, wr: 1'b1, rg: 4'd15, data: 32'hFFFF_0015});
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_gnt();
            e = exp_q.pop_front();
            vectors++; if (gnt !== e.oh) begin miscompares++; $display("FAIL mrr_gnt_after[%0d] got %b want %b", k, gnt, e.oh); end
            vectors++; if (rf_write_reg !== e.rg || rf_write_value !== e.data) begin
                miscompares++; $display("FAIL mrr_payload[%0d] got %h/%h want %h/%h", k, rf_write_reg, rf_write_value, e.rg, e.data); end
        end
        repeat (4) tick();
        vectors++; if (rsp_seen !== 1'b0) begin miscompares++; $display("FAIL mrr_no_rsp got %b want 0", rsp_seen); end
        vectors++; if (exp_q.size() != 0 || rsp_q.size() != 0) begin
            miscompares++; $display("FAIL sb_drain got %0d/%0d want 0/0", exp_q.size(), rsp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hEE00_0000 + i;
        req = '0;
        req_write = '0;
        req_reg = '0;
        req_wdata = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_busy_block();
        test_mid_read_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
